// File: rtl/link_frame_scheduler.sv
// One-byte-in-flight scheduler across the modulation/channel/demodulation medium with frame preamble control.
// Optional error counter enabled by defining LINK_ERRCNT_EN (adds err_count / err_clear ports).
`timescale 1ns/1ps

module link_frame_scheduler #(
  parameter int CHAN_LAT     = 2,
  parameter int FRAME_LEN    = 256,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  med_data_in,
  input  logic [7:0]  med_data_out,
  output logic        med_noise_off,
  output logic [15:0] byte_idx,
  output logic        frame_done,
`ifdef LINK_ERRCNT_EN
  output logic [15:0] err_count,
  input  logic        err_clear,
`endif
  output logic        busy
);

  localparam logic [3:0]  LAT_LOAD = 4'(CHAN_LAT);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0] PRE_LEN  = 16'(PREAMBLE_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t     state, state_nx;
  logic [3:0] lat_cnt;
  logic       accept, capture, handshake;

  assign in_ready  = (state == IDLE) && enable;
  assign accept    = in_ready && in_valid;
  assign capture   = (state == WAIT) && (lat_cnt == 4'd1);
  assign handshake = (state == HOLD) && out_valid && out_ready;
  assign busy      = (state != IDLE);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = WAIT;
      WAIT:    if (capture)   state_nx = HOLD;
      HOLD:    if (handshake) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      med_data_in   <= 8'h00;
      med_noise_off <= 1'b1;
      out_data      <= 8'h00;
      out_valid     <= 1'b0;
      byte_idx      <= 16'h0000;
      frame_done    <= 1'b0;
      lat_cnt       <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      // Medium inputs only move on acceptance, so they stay quiet while idle.
      if (accept) begin
        med_data_in   <= in_data;
        med_noise_off <= (byte_idx < PRE_LEN);
        lat_cnt       <= LAT_LOAD;
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (capture) begin
        out_data  <= med_data_out;
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        if (byte_idx == LAST_IDX) begin
          byte_idx   <= 16'h0000;
          frame_done <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 16'd1;
        end
      end
    end
  end

`ifdef LINK_ERRCNT_EN
  logic [7:0] tx_reg;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg    <= 8'h00;
      err_count <= 16'h0000;
    end else begin
      if (accept) tx_reg <= in_data;
      if (err_clear)
        err_count <= 16'h0000;
      else if (handshake && (out_data != tx_reg) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
